exec_result_queue: RTL
======================

EXEC_RESULT_QUEUE -- requirements
Module: exec_result_queue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the result datapath.
REQ-002 SHALL have parameter DEPTH, fixed at 2, number of buffered entries; other values unsupported.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port inValid  input  1  execute stage presents a result this cycle.
REQ-006 SHALL have port inReady  output  1  queue accepts a result this cycle.
REQ-007 SHALL have port inResult  input  DATA_WIDTH  ALU result from execute stage.
REQ-008 SHALL have port inRd  input  5  destination register index.
REQ-009 SHALL have port inRegWrite  input  1  result is to be written to the register file.
REQ-010 SHALL have port flush  input  1  discard all buffered results (branch mispredict / trap).
REQ-011 SHALL have port outValid  output  1  head entry available to writeback.
REQ-012 SHALL have port outReady  input  1  writeback consumes head entry this cycle.
REQ-013 SHALL have ports outResult  output  DATA_WIDTH, outRd  output  5, outRegWrite  output  1  head entry fields.
REQ-014 SHALL have port fwdRd  input  5  register index looked up by the decode stage for forwarding.
REQ-015 SHALL have ports fwdHit  output  1, fwdData  output  DATA_WIDTH  forwarding lookup result.
REQ-016 SHALL have port count  output  2  number of valid entries (0..2).

Function
REQ-017 SHALL be a 2-entry in-order FIFO with head/tail pointers wrapping modulo 2 and a registered entry count.
REQ-018 SHALL drive inReady = (count < 2), derived from registered state only, with no combinational path from outReady or inValid.
REQ-019 SHALL push on a rising edge when inValid && inReady && !flush, writing {inResult, inRd, inRegWrite && (inRd != 0)} at the tail.
REQ-020 SHALL pop on a rising edge when outValid && outReady && !flush, advancing the head.
REQ-021 SHALL drive outValid = (count != 0); outResult/outRd/outRegWrite SHALL be the head entry fields, and 0 when count == 0.
REQ-022 SHALL, on simultaneous push and pop (only possible at count == 1), keep count at 1 and present the newly pushed entry at the head next cycle.
REQ-023 SHALL, at count == 2, reject input (inReady = 0) even when outReady = 1; the freed slot is visible as inReady = 1 in the following cycle.
REQ-024 SHALL hold outValid and head fields stable while outValid && !outReady and no flush.
REQ-025 SHALL, on flush, set count, head and tail to 0 at the next edge, ignoring any concurrent push or pop.
REQ-026 SHALL compute fwdHit combinationally: 1 iff fwdRd != 0 and some valid entry has regWrite = 1 and rd == fwdRd.
REQ-027 SHALL, when both entries match, forward from the youngest (tail-side) entry; fwdData SHALL be 0 when fwdHit = 0.
REQ-028 SHALL not forward an entry in the cycle it is being pushed (lookup reflects registered state only).

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously clear count, head, tail and entry valid state; outputs SHALL be inReady = 1, outValid = 0, outResult = 0, outRd = 0, outRegWrite = 0, fwdHit = 0, fwdData = 0, count = 0.
REQ-030 SHALL, on reset asserted mid-operation, discard all buffered entries; first push is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL cover: push {0x0000_0005, rd=3, wr=1} with outReady=0 -> next cycle outValid=1, outResult=5, outRd=3, count=1, inReady=1.
REQ-032 SHALL cover: push 0xAAAA_0001 then 0xAAAA_0002 with outReady=0 -> count=2, inReady=0; third push ignored; then outReady=1 for 2 cycles -> outputs 0xAAAA_0001 then 0xAAAA_0002, count=0.
REQ-033 SHALL cover: count=1, simultaneous push 0x22 and pop -> count stays 1, outResult=0x22 next cycle.
REQ-034 SHALL cover: entries {rd=7, 0x11} older and {rd=7, 0x99} younger, fwdRd=7 -> fwdHit=1, fwdData=0x99; fwdRd=0 with a rd=0 entry -> fwdHit=0, and that entry's outRegWrite=0.
REQ-035 SHALL cover: count=2, flush=1 together with inValid=1 and outReady=1 -> next cycle count=0, outValid=0, inReady=1, fwdHit=0.
REQ-036 SHALL cover: count=2, rst_n pulsed low between clock edges -> outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/exec_result_queue.sv
// Two-entry in-order result queue between execute and writeback, with a
// register-index lookup that lets decode forward from buffered results.
module exec_result_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inResult,
  input  logic [4:0]            inRd,
  input  logic                  inRegWrite,
  input  logic                  flush,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outResult,
  output logic [4:0]            outRd,
  output logic                  outRegWrite,
  input  logic [4:0]            fwdRd,
  output logic                  fwdHit,
  output logic [DATA_WIDTH-1:0] fwdData,
  output logic [1:0]            count
);

  logic                  head_reg, head_next;
  logic                  tail_reg, tail_next;
  logic [1:0]            count_reg, count_next;
  logic [DATA_WIDTH-1:0] result_reg [DEPTH];
  logic [4:0]            rd_reg     [DEPTH];
  logic                  wr_reg     [DEPTH];
  logic                  push;
  logic                  pop;
  logic                  young_idx;
  logic                  young_match;
  logic                  old_match;

  // Handshake flags come only from registered occupancy, never from outReady.
  assign inReady  = (count_reg != 2'd2);
  assign outValid = (count_reg != 2'd0);
  assign push     = inValid && inReady && !flush;
  assign pop      = outValid && outReady && !flush;
  assign count    = count_reg;

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = 1'b0;
      tail_next  = 1'b0;
      count_next = 2'd0;
    end else begin
      if (push) tail_next = ~tail_reg;
      if (pop)  head_next = ~head_reg;
      case ({push, pop})
        2'b10:   count_next = count_reg + 2'd1;
        2'b01:   count_next = count_reg - 2'd1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic SLOT = 1'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result_reg[gi] <= '0;
          rd_reg[gi]     <= 5'd0;
          wr_reg[gi]     <= 1'b0;
        end else if (push && (tail_reg == SLOT)) begin
          result_reg[gi] <= inResult;
          rd_reg[gi]     <= inRd;
          wr_reg[gi]     <= inRegWrite && (inRd != 5'd0);
        end
      end
    end
  endgenerate

  assign outResult   = outValid ? result_reg[head_reg] : '0;
  assign outRd       = outValid ? rd_reg[head_reg]     : 5'd0;
  assign outRegWrite = outValid ? wr_reg[head_reg]     : 1'b0;

  // Youngest entry sits just behind the tail; the older one is the head only when full.
  assign young_idx   = ~tail_reg;
  assign young_match = (count_reg != 2'd0) && wr_reg[young_idx] &&
                       (rd_reg[young_idx] == fwdRd) && (fwdRd != 5'd0);
  assign old_match   = (count_reg == 2'd2) && wr_reg[head_reg] &&
                       (rd_reg[head_reg] == fwdRd) && (fwdRd != 5'd0);

  assign fwdHit  = young_match || old_match;
  assign fwdData = young_match ? result_reg[young_idx] :
                   old_match   ? result_reg[head_reg]  : '0;

endmodule
